local_ejection_sink: RTL and testbench

Terminal consumer on a router's LOCAL output port; the stage directly downstream of the router's local ejection path. Each mesh tile instantiates it beside its traffic generator. It accepts ejected flits under on/off flow control and buffers them in a small FIFO. It drains the FIFO at a rate set by the core, checks packet framing and destination address, and exposes packet/flit counters and sticky error flags to the bench.

---
 rtl/local_ejection_sink.sv | 243 ++++++++++++++++++++++++
 tb/tb_local_ejection_sink.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/local_ejection_sink.sv
// ---------------------------------------------------------------------------
// local_ejection_sink
//
// Terminal consumer on a router's LOCAL output port. Ejected flits are
// accepted under on/off flow control into a small FIFO, drained at the rate
// the core allows, and checked for packet framing and destination address.
// Packet/flit counters and sticky error flags are exposed for observation.
//
// Ports
//   clk             in   system clock
//   reset_n         in   asynchronous active-low reset
//   i_flit          in   ejected flit (type + destination)
//   i_rec_req       in   i_flit is valid this cycle
//   o_rec_ack       out  on/off permission to the router (1 = may send)
//   i_drain_en      in   core ready, one FIFO pop per cycle
//   o_pkt_valid     out  one-cycle pulse on packet completion
//   o_pkt_len       out  length of the completed packet
//   o_pkt_count     out  completed packets (wraps)
//   o_flit_count    out  flits written into the FIFO (wraps)
//   o_err_dest      out  sticky: head carried a foreign destination
//   o_err_seq       out  sticky: framing violation
//   o_err_overflow  out  sticky: flit arrived while the FIFO was full
// ---------------------------------------------------------------------------
package noc_pkg;
    typedef enum logic [1:0] {
        HEAD      = 2'd0,
        BODY      = 2'd1,
        TAIL      = 2'd2,
        HEAD_TAIL = 2'd3
    } flit_type_t;

    typedef struct packed {
        logic [3:0] xaddr;
        logic [3:0] yaddr;
    } router_conf_t;

    typedef struct packed {
        flit_type_t   flit_type;
        router_conf_t dest;
    } FLIT_t;
endpackage

module local_ejection_sink
    import noc_pkg::*;
#(
    parameter router_conf_t router_conf   = '{xaddr: 4'd0, yaddr: 4'd0},
    parameter int           FIFO_DEPTH    = 8,
    parameter int           OFF_THRESHOLD = 6,
    parameter int           MAX_PKT_LEN   = 16,
    localparam int          LEN_W         = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  FLIT_t            i_flit,
    input  logic             i_rec_req,
    output logic             o_rec_ack,
    input  logic             i_drain_en,
    output logic             o_pkt_valid,
    output logic [LEN_W-1:0] o_pkt_len,
    output logic [31:0]      o_pkt_count,
    output logic [31:0]      o_flit_count,
    output logic             o_err_dest,
    output logic             o_err_seq,
    output logic             o_err_overflow
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   THR_C   = (PTR_W + 1)'(OFF_THRESHOLD);
    localparam logic [PTR_W:0]   ONE_C   = (PTR_W + 1)'(1);
    localparam logic [LEN_W-1:0] MAX_C   = LEN_W'(MAX_PKT_LEN);
    localparam logic [LEN_W-1:0] LEN1_C  = LEN_W'(1);

    typedef enum logic {S_IDLE = 1'b0, S_IN_PKT = 1'b1} state_t;

    // ---------------- FIFO ----------------
    FLIT_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q, count_d;
    logic              rec_ack_q;
    logic              err_overflow_q, err_overflow_d;
    logic [31:0]       flit_count_q, flit_count_d;

    logic              full, empty, pop, push;
    FLIT_t             pop_flit;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign pop      = i_drain_en && !empty;
    // A full FIFO still takes the flit when a pop frees a slot this cycle.
    assign push     = i_rec_req && (!full || pop);
    assign pop_flit = mem_q[rd_ptr_q];

    always_comb begin
        count_d        = count_q;
        err_overflow_d = err_overflow_q;
        flit_count_d   = flit_count_q;
        if (push && !pop) begin
            count_d = count_q + ONE_C;
        end else if (!push && pop) begin
            count_d = count_q - ONE_C;
        end
        if (push) begin
            flit_count_d = flit_count_q + 32'd1;
        end
        if (i_rec_req && !push) begin
            err_overflow_d = 1'b1;
        end
    end

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_flit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            rec_ack_q      <= 1'b1;
            err_overflow_q <= 1'b0;
            flit_count_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q        <= count_d;
            // Registered off the next occupancy so ack drops one cycle
            // after the threshold is reached; the remaining slots absorb
            // the flit the router may still send in that cycle.
            rec_ack_q      <= (count_d < THR_C);
            err_overflow_q <= err_overflow_d;
            flit_count_q   <= flit_count_d;
        end
    end

    // ---------------- Framing FSM ----------------
    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic [LEN_W-1:0]  pkt_len_q, pkt_len_d;
    logic [31:0]       pkt_count_q, pkt_count_d;
    logic              err_dest_q, err_dest_d;
    logic              err_seq_q, err_seq_d;
    logic              start_head;
    logic              complete;
    logic [LEN_W-1:0]  cmpl_len;
    logic              is_head;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        pkt_valid_d = 1'b0;
        pkt_len_d   = pkt_len_q;
        pkt_count_d = pkt_count_q;
        err_dest_d  = err_dest_q;
        err_seq_d   = err_seq_q;
        start_head  = 1'b0;
        complete    = 1'b0;
        cmpl_len    = '0;
        is_head     = (pop_flit.flit_type == HEAD) ||
                      (pop_flit.flit_type == HEAD_TAIL);

        if (pop) begin
            if (state_q == S_IN_PKT) begin
                if (is_head) begin
                    // Open packet is abandoned uncounted; the new head
                    // starts afresh.
                    err_seq_d  = 1'b1;
                    start_head = 1'b1;
                end else if (len_q == MAX_C) begin
                    // One more flit would exceed the legal length.
                    err_seq_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (pop_flit.flit_type == TAIL) begin
                    complete = 1'b1;
                    cmpl_len = len_q + LEN1_C;
                    state_d  = S_IDLE;
                end else begin
                    len_d = len_q + LEN1_C;
                end
            end else begin
                if (is_head) begin
                    start_head = 1'b1;
                end else begin
                    err_seq_d = 1'b1;
                end
            end

            if (start_head) begin
                if (pop_flit.dest != router_conf) begin
                    err_dest_d = 1'b1;
                end
                if (pop_flit.flit_type == HEAD) begin
                    len_d   = LEN1_C;
                    state_d = S_IN_PKT;
                end else begin
                    complete = 1'b1;
                    cmpl_len = LEN1_C;
                    state_d  = S_IDLE;
                end
            end
        end

        if (complete) begin
            pkt_valid_d = 1'b1;
            pkt_len_d   = cmpl_len;
            pkt_count_d = pkt_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            pkt_valid_q <= 1'b0;
            pkt_len_q   <= '0;
            pkt_count_q <= '0;
            err_dest_q  <= 1'b0;
            err_seq_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_len_q   <= pkt_len_d;
            pkt_count_q <= pkt_count_d;
            err_dest_q  <= err_dest_d;
            err_seq_q   <= err_seq_d;
        end
    end

    assign o_rec_ack      = rec_ack_q;
    assign o_pkt_valid    = pkt_valid_q;
    assign o_pkt_len      = pkt_len_q;
    assign o_pkt_count    = pkt_count_q;
    assign o_flit_count   = flit_count_q;
    assign o_err_dest     = err_dest_q;
    assign o_err_seq      = err_seq_q;
    assign o_err_overflow = err_overflow_q;

endmodule

// File: tb/tb_local_ejection_sink.sv
// ---------------------------------------------------------------------------
// Bench for local_ejection_sink. Expected packet lengths are queued as
// stimulus is issued; a monitor pops one entry per o_pkt_valid pulse.
// Counters and flags are checked against hand-computed values.
// ---------------------------------------------------------------------------
module tb_local_ejection_sink;
    import noc_pkg::*;

    localparam int LEN_W = 5;

    logic             clk;
    logic             reset_n;
    FLIT_t            i_flit;
    logic             i_rec_req;
    logic             o_rec_ack;
    logic             i_drain_en;
    logic             o_pkt_valid;
    logic [LEN_W-1:0] o_pkt_len;
    logic [31:0]      o_pkt_count;
    logic [31:0]      o_flit_count;
    logic             o_err_dest;
    logic             o_err_seq;
    logic             o_err_overflow;

    int vectors;
    int miscompares;
    int exp_q[$];

    local_ejection_sink #(
        .router_conf  ('{xaddr: 4'd0, yaddr: 4'd0}),
        .FIFO_DEPTH   (8),
        .OFF_THRESHOLD(6),
        .MAX_PKT_LEN  (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_flit        (i_flit),
        .i_rec_req     (i_rec_req),
        .o_rec_ack     (o_rec_ack),
        .i_drain_en    (i_drain_en),
        .o_pkt_valid   (o_pkt_valid),
        .o_pkt_len     (o_pkt_len),
        .o_pkt_count   (o_pkt_count),
        .o_flit_count  (o_flit_count),
        .o_err_dest    (o_err_dest),
        .o_err_seq     (o_err_seq),
        .o_err_overflow(o_err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every completion must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && o_pkt_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pkt: got len %0d, expected no packet", o_pkt_len);
            end else begin
                chk("pkt_len", 32'(o_pkt_len), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input flit_type_t t, input logic [3:0] x, input logic [3:0] y);
        i_flit.flit_type  = t;
        i_flit.dest.xaddr = x;
        i_flit.dest.yaddr = y;
        i_rec_req = 1'b1;
        @(posedge clk);
        #1;
        i_rec_req = 1'b0;
    endtask

    // Router model honouring on/off flow control, with a bounded wait.
    task automatic send_obey(input flit_type_t t);
        int g;
        g = 0;
        while (o_rec_ack !== 1'b1 && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("ack_wait_timeout", (g >= 50) ? 32'd1 : 32'd0, 32'd0);
        send(t, 4'd0, 4'd0);
    endtask

    task automatic chk_reset_values();
        chk("rst_rec_ack",      32'(o_rec_ack),      32'd1);
        chk("rst_pkt_valid",    32'(o_pkt_valid),    32'd0);
        chk("rst_pkt_len",      32'(o_pkt_len),      32'd0);
        chk("rst_pkt_count",    o_pkt_count,         32'd0);
        chk("rst_flit_count",   o_flit_count,        32'd0);
        chk("rst_err_dest",     32'(o_err_dest),     32'd0);
        chk("rst_err_seq",      32'(o_err_seq),      32'd0);
        chk("rst_err_overflow", 32'(o_err_overflow), 32'd0);
    endtask

    task automatic do_reset();
        chk("pending_before_reset", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        reset_n = 1'b0;
        #3;
        chk_reset_values();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        i_rec_req   = 1'b0;
        i_drain_en  = 1'b0;
        i_flit      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values();
        reset_n = 1'b1;
        wait_cycles(1);

        // Single HEAD_TAIL to own tile.
        i_drain_en = 1'b1;
        exp_q.push_back(1);
        send(HEAD_TAIL, 4'd0, 4'd0);
        wait_cycles(4);
        chk("t1_pkt_count",  o_pkt_count,  32'd1);
        chk("t1_flit_count", o_flit_count, 32'd1);
        chk("t1_err_dest",   32'(o_err_dest), 32'd0);
        chk("t1_err_seq",    32'(o_err_seq),  32'd0);

        // Five-flit packet back to back.
        exp_q.push_back(5);
        send(HEAD, 4'd0, 4'd0);
        repeat (3) send(BODY, 4'd0, 4'd0);
        send(TAIL, 4'd0, 4'd0);
        wait_cycles(4);
        chk("t2_pkt_count",  o_pkt_count,  32'd2);
        chk("t2_flit_count", o_flit_count, 32'd6);

        // Drain off, router obeys ack: 8 flits as packets of 1, 3 and 4.
        i_drain_en = 1'b0;
        exp_q.push_back(1);
        exp_q.push_back(3);
        exp_q.push_back(4);
        send_obey(HEAD_TAIL);
        send_obey(HEAD);
        send_obey(BODY);
        send_obey(TAIL);
        send_obey(HEAD);
        chk("t3_ack_before_thr", 32'(o_rec_ack), 32'd1);
        send_obey(BODY);
        chk("t3_ack_after_6th",  32'(o_rec_ack), 32'd0);
        chk("t3_flit_count_6",   o_flit_count,   32'd12);
        i_drain_en = 1'b1;
        send_obey(BODY);
        send_obey(TAIL);
        wait_cycles(12);
        chk("t3_err_overflow", 32'(o_err_overflow), 32'd0);
        chk("t3_pkt_count",    o_pkt_count,  32'd5);
        chk("t3_flit_count",   o_flit_count, 32'd14);
        chk("t3_ack_restored", 32'(o_rec_ack), 32'd1);

        // Drain off, router ignores ack: 9 flits into depth 8.
        i_drain_en = 1'b0;
        for (int i = 0; i < 9; i++) send(HEAD_TAIL, 4'd0, 4'd0);
        chk("t4_err_overflow", 32'(o_err_overflow), 32'd1);
        chk("t4_flit_count",   o_flit_count, 32'd22);
        for (int i = 0; i < 8; i++) exp_q.push_back(1);
        i_drain_en = 1'b1;
        wait_cycles(12);
        chk("t4_pkt_count", o_pkt_count, 32'd13);

        // Lone TAIL.
        chk("t5_err_seq_before", 32'(o_err_seq), 32'd0);
        send(TAIL, 4'd0, 4'd0);
        wait_cycles(4);
        chk("t5_err_seq",    32'(o_err_seq), 32'd1);
        chk("t5_pkt_count",  o_pkt_count,  32'd13);
        chk("t5_flit_count", o_flit_count, 32'd23);

        // HEAD, BODY, HEAD, TAIL: first packet aborted, second has len 2.
        do_reset();
        i_drain_en = 1'b1;
        exp_q.push_back(2);
        send(HEAD, 4'd0, 4'd0);
        send(BODY, 4'd0, 4'd0);
        send(HEAD, 4'd0, 4'd0);
        send(TAIL, 4'd0, 4'd0);
        wait_cycles(4);
        chk("t6_err_seq",   32'(o_err_seq), 32'd1);
        chk("t6_pkt_count", o_pkt_count, 32'd1);
        chk("t6_err_dest",  32'(o_err_dest), 32'd0);

        // Foreign destination: flagged but still counted.
        do_reset();
        i_drain_en = 1'b1;
        exp_q.push_back(2);
        send(HEAD, 4'd1, 4'd0);
        send(TAIL, 4'd0, 4'd0);
        wait_cycles(4);
        chk("t7_err_dest",  32'(o_err_dest), 32'd1);
        chk("t7_err_seq",   32'(o_err_seq),  32'd0);
        chk("t7_pkt_count", o_pkt_count, 32'd1);

        // Length boundary: 16 flits legal, 17th flit aborts.
        do_reset();
        i_drain_en = 1'b1;
        exp_q.push_back(16);
        send(HEAD, 4'd0, 4'd0);
        repeat (14) send(BODY, 4'd0, 4'd0);
        send(TAIL, 4'd0, 4'd0);
        wait_cycles(4);
        chk("t8_err_seq_legal", 32'(o_err_seq), 32'd0);
        chk("t8_pkt_count_16",  o_pkt_count, 32'd1);
        send(HEAD, 4'd0, 4'd0);
        repeat (16) send(BODY, 4'd0, 4'd0);
        exp_q.push_back(1);
        send(HEAD_TAIL, 4'd0, 4'd0);
        wait_cycles(4);
        chk("t8_err_seq_long",  32'(o_err_seq), 32'd1);
        chk("t8_pkt_count",     o_pkt_count,  32'd2);
        chk("t8_flit_count",    o_flit_count, 32'd34);
        chk("t8_err_overflow",  32'(o_err_overflow), 32'd0);

        // Asynchronous reset mid-packet with 4 flits buffered.
        do_reset();
        i_drain_en = 1'b0;
        send(HEAD, 4'd0, 4'd0);
        repeat (3) send(BODY, 4'd0, 4'd0);
        chk("t9_flit_count_pre", o_flit_count, 32'd4);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_values();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        i_drain_en = 1'b1;
        exp_q.push_back(1);
        send(HEAD_TAIL, 4'd0, 4'd0);
        wait_cycles(4);
        chk("t9_pkt_count",  o_pkt_count,  32'd1);
        chk("t9_flit_count", o_flit_count, 32'd1);
        chk("t9_err_seq",    32'(o_err_seq), 32'd0);

        wait_cycles(4);
        chk("pending_at_end", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
